// File: rtl/mcode_exec_unit.sv
// Two-stage executor for the 14-bit machineCode control word: accept/read, then execute/writeback.
// Define MCODE_EXEC_FWD_EN to bypass writeback data into the operand read instead of stalling.
module mcode_exec_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [13:0]       machineCode,
  input  logic              mc_valid,
  output logic              mc_ready,
  output logic [DATA_W-1:0] outPort,
  output logic              out_valid,
  output logic              busy
);

  logic              w_srcSel;
  logic [2:0]        w_raddr1;
  logic [2:0]        w_raddr2;
  logic [2:0]        w_waddr;
  logic              w_wrEn;
  logic [1:0]        w_aluOp;
  logic              w_outLoad;

  assign w_srcSel  = machineCode[13];
  assign w_raddr1  = machineCode[12:10];
  assign w_raddr2  = machineCode[9:7];
  assign w_waddr   = machineCode[6:4];
  assign w_wrEn    = machineCode[3];
  assign w_aluOp   = machineCode[2:1];
  assign w_outLoad = machineCode[0];

  logic [DATA_W-1:0] r_rf [0:7];

  logic              r_exValid;
  logic              r_exSrcSel;
  logic [2:0]        r_exWaddr;
  logic              r_exWrEn;
  logic [1:0]        r_exAluOp;
  logic              r_exOutLoad;
  logic [DATA_W-1:0] r_exA;
  logic [DATA_W-1:0] r_exB;
  logic [DATA_W-1:0] r_outPort;
  logic              r_outValid;

  logic [DATA_W-1:0] w_rfRd1;
  logic [DATA_W-1:0] w_rfRd2;
  logic [DATA_W-1:0] w_aluRes;
  logic [DATA_W-1:0] w_wrData;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;
  logic              w_exWrite;
  logic              w_raw1;
  logic              w_raw2;
  logic              w_accept;

  // R0 is hardwired to zero on the read side as well as never being written
  assign w_rfRd1 = (w_raddr1 == 3'd0) ? '0 : r_rf[w_raddr1];
  assign w_rfRd2 = (w_raddr2 == 3'd0) ? '0 : r_rf[w_raddr2];

  always_comb begin
    w_aluRes = '0;
    case (r_exAluOp)
      2'b00:   w_aluRes = r_exA + r_exB;
      2'b01:   w_aluRes = r_exA - r_exB;
      2'b10:   w_aluRes = r_exA & r_exB;
      default: w_aluRes = r_exA | r_exB;
    endcase
  end

  assign w_wrData  = r_exSrcSel ? DATA_W'(1) : w_aluRes;
  assign w_exWrite = r_exValid && r_exWrEn && (r_exWaddr != 3'd0);
  assign w_raw1    = w_exWrite && (w_raddr1 == r_exWaddr);
  assign w_raw2    = w_exWrite && (w_raddr2 == r_exWaddr);

`ifdef MCODE_EXEC_FWD_EN
  assign w_opA    = w_raw1 ? w_wrData : w_rfRd1;
  assign w_opB    = w_raw2 ? w_wrData : w_rfRd2;
  assign mc_ready = !reset;
`else
  // A dependent word waits one cycle so the RF write lands before it reads
  assign w_opA    = w_rfRd1;
  assign w_opB    = w_rfRd2;
  assign mc_ready = !reset && !(w_raw1 || w_raw2);
`endif

  assign w_accept = mc_valid && mc_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      r_exValid   <= 1'b0;
      r_exSrcSel  <= 1'b0;
      r_exWaddr   <= 3'd0;
      r_exWrEn    <= 1'b0;
      r_exAluOp   <= 2'b00;
      r_exOutLoad <= 1'b0;
      r_exA       <= '0;
      r_exB       <= '0;
      r_outPort   <= '0;
      r_outValid  <= 1'b0;
    end else begin
      r_exValid <= w_accept;
      if (w_accept) begin
        r_exSrcSel  <= w_srcSel;
        r_exWaddr   <= w_waddr;
        r_exWrEn    <= w_wrEn;
        r_exAluOp   <= w_aluOp;
        r_exOutLoad <= w_outLoad;
        r_exA       <= w_opA;
        r_exB       <= w_opB;
      end
      if (w_exWrite) r_rf[r_exWaddr] <= w_wrData;
      if (r_exValid && r_exOutLoad) r_outPort <= r_exA;
      r_outValid <= r_exValid && r_exOutLoad;
    end
  end

  assign outPort   = r_outPort;
  assign out_valid = r_outValid;
  assign busy      = r_exValid;

endmodule

// File: doc/mcode_exec_unit.md
# mcode_exec_unit

Consumer end of the 14-bit `machineCode` control word stream. It accepts one control word per handshake, decodes its fields, and reads an 8×8 register file. It executes the selected ALU operation in a two-stage pipeline (accept/read, execute/writeback) and loads `outPort` on `OutLoad`. It sits between any `machineCode` producer (FSM control unit, instruction ROM sequencer) and the board output.

## Interface
- `DATA_W`: default 8. Register, ALU and `outPort` width.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `machineCode`, input, 14: control word with fields:
  - `[13]` RFSrcMuxSel
  - `[12:10]` raddr1
  - `[9:7]` raddr2
  - `[6:4]` waddr
  - `[3]` wr_en
  - `[2:1]` ALUop
  - `[0]` OutLoad
- `mc_valid`, input, 1: `machineCode` is valid this cycle.
- `mc_ready`, output, 1: the unit can accept this cycle. A word transfers when `mc_valid && mc_ready`.
- `outPort`, output, DATA_W: registered output port.
- `out_valid`, output, 1: one-cycle pulse the cycle after `outPort` is updated.
- `busy`, output, 1: the execute stage holds a valid word.

## Operation
- **Register file:** R0..R7, each DATA_W wide.
  - R0 always reads 0; writes to R0 are discarded.
- **Accept stage:** on transfer, read rdata1 = R[raddr1] and rdata2 = R[raddr2]. Latch both operands with the decoded fields into the execute register (`ex_valid` = 1).
- **ALU operations:**
  - ALUop 00: A+B
  - ALUop 01: A−B
  - ALUop 10: A&B
  - ALUop 11: A|B
  - All results are DATA_W bits, modulo 2^DATA_W. No carry or borrow flags (0xFF+0x01=0x00, 0x00−0x01=0xFF).
- **Write data:** RFSrcMuxSel=1 selects the constant 1 (zero-extended). RFSrcMuxSel=0 selects the ALU result.
- **Execute stage** (`ex_valid`):
  - If wr_en and waddr≠0: R[waddr] ← write data.
  - If OutLoad: `outPort` ← operand A (rdata1) and `out_valid` pulses.
  - Both actions take effect in the same cycle when both fields are set.
- **No-op word:** wr_en=0 and OutLoad=0 is legal. It occupies a slot and produces no side effect.
- **RAW hazard:** the incoming word has raddr1 or raddr2 equal to the execute-stage waddr, with wr_en=1 and waddr≠0. Resolution depends on configuration (see below).
- **Back-pressure:** if `mc_valid` is low, a bubble enters the execute stage (`ex_valid` = 0).
- **Reset:** applies at the next edge even mid-pipeline. The in-flight word is discarded and its write is not performed.

## Timing
- Transfer in cycle N, then:
  - execute register loads at the edge ending N;
  - RF write and `outPort` load occur at the edge ending N+1;
  - `out_valid` is high during N+2.
- Throughput: one word per cycle when no stall occurs.
- While `reset` is high, and on the first cycle after release:
  - R0..R7 = 0
  - `outPort` = 0
  - `out_valid` = 0
  - `ex_valid` = 0
  - `busy` = 0
  - `mc_ready` = 0 during reset, 1 in the first cycle after release.
- `mc_ready` is combinational from `machineCode` and the execute-stage fields, so it can depend on the incoming word. A producer must hold `machineCode` stable while `mc_valid` is high and `mc_ready` is low.
- A write and a read of the same register in the same cycle: the read returns the new value, via forwarding or via the stall.
- Two consecutive OutLoad words produce two consecutive `out_valid` pulses.

## Configuration
- `MCODE_EXEC_FWD_EN` defined:
  - The execute-stage write data bypasses into the accept-stage operand read on a RAW match.
  - `mc_ready` = 1 whenever not in reset.
  - No stalls.
- `MCODE_EXEC_FWD_EN` undefined:
  - On a RAW match, `mc_ready` = 0 for exactly one cycle while the producing word writes back.
  - The word is accepted the following cycle and reads the written RF value.
- Architectural results are identical in both builds; only cycle counts differ.

## Test plan
- **Reset defaults:** assert reset for 3 cycles with `mc_valid`=1 → no RF writes; `outPort`=0x00; `out_valid`=0; `mc_ready`=0 during reset, 1 after release.
- **Full program:** R1=0, R2=0, R3=1 (RFSrcMuxSel), R1+=R3, R2+=R3, R3=R1−R2, R4=R1&R3, R5=R2|R3, R6=R1+R2, R7=R2+R6, then OutLoad raddr1=7.
  - Result: `outPort`=0x03 with a single `out_valid` pulse.
  - With FWD_EN: 11 words accepted in 11 consecutive cycles.
  - Without FWD_EN: `mc_ready` drops on each dependent word.
- **Single hazard encoding:** word 0x0598 (R1=R1+R3) immediately after R3=1 → R1=0x01. Zero stall cycles with FWD_EN, exactly one without.
- **Wrap-around:** load R1=1, then R2=R0−R1 (0xFF), then R3=R2+R1 → R2=0xFF, R3=0x00. OutLoad raddr1=2 gives `outPort`=0xFF.
- **R0 protection:** word with waddr=0, wr_en=1, RFSrcMuxSel=1, then OutLoad raddr1=0 → `outPort`=0x00.
- **Reset mid-pipeline:** accept a word writing R5=1, assert reset the following cycle → R5=0 and `out_valid` never pulses.
